// File: rtl/word_assembler_16b_if.sv
// Byte-in / word-out bus of the 16-bit word assembler.
// The upstream feeder and downstream register side share this one bundle.
interface word_assembler_16b_if;
   logic [7:0]  input_byte;
   logic        input_valid;
   logic        input_ready;
   logic        input_abort;
   logic        downstream_ready;
   logic [15:0] output_word;
   logic        output_clock_enable;
   logic        output_timeout;

   modport master (
      output input_byte, input_valid, input_abort, downstream_ready,
      input  input_ready, output_word, output_clock_enable, output_timeout
   );

   modport slave (
      input  input_byte, input_valid, input_abort, downstream_ready,
      output input_ready, output_word, output_clock_enable, output_timeout
   );
endinterface

// File: rtl/word_assembler_16b.sv
// Assembles two consecutive bytes into a 16-bit word and holds it with a
// clock-enable strobe until the downstream register loads it.
module word_assembler_16b #(
   parameter bit          LOW_FIRST = 1'b1,
   parameter int unsigned TIMEOUT   = 8,
   parameter int unsigned CNT_W     = 4
) (
   input logic                 clock,
   input logic                 clear_n,
   word_assembler_16b_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HAVE_ONE = 2'd1,
      PRESENT  = 2'd2
   } state_t;

   // Counter value on the edge before it would reach TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       hold_q;
   logic [15:0]      word_q;
   logic             ce_q;
   logic             timeout_q;
   logic [15:0]      word_d;

   always_comb begin
      word_d = LOW_FIRST ? {bus.input_byte, hold_q} : {hold_q, bus.input_byte};
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hold_q    <= 8'h00;
         word_q    <= 16'h0000;
         ce_q      <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (bus.input_abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (bus.input_valid) begin
                     hold_q  <= bus.input_byte;
                     cnt_q   <= '0;
                     state_q <= HAVE_ONE;
                  end
               end
               HAVE_ONE: begin
                  // An accept on the deadline cycle beats the timeout.
                  if (bus.input_valid) begin
                     word_q  <= word_d;
                     ce_q    <= 1'b1;
                     state_q <= PRESENT;
                  end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                     cnt_q     <= '0;
                     timeout_q <= 1'b1;
                     state_q   <= IDLE;
                  end else if (TIMEOUT != 0) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               PRESENT: begin
                  if (bus.downstream_ready) begin
                     ce_q    <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  ce_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.input_ready         = (state_q != PRESENT);
   assign bus.output_word         = word_q;
   assign bus.output_clock_enable = ce_q;
   assign bus.output_timeout      = timeout_q;

endmodule
